// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed when the op is accepted and held until the countdown commits it.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, abs_a, abs_b;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  assign divisor = (b == 32'd0) ? 32'd1 : b;
  assign abs_a   = a[31] ? (~a + 32'd1) : a;
  assign abs_b   = divisor[31] ? (~divisor + 32'd1) : divisor;
  assign q_mag   = abs_a / abs_b;
  assign r_mag   = abs_a % abs_b;
  assign q_s     = (a[31] ^ divisor[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s     = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u     = a / divisor;
  assign r_u     = a % divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1) && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      case (md_op)
        OP_MULT: begin
          cnt     <= CW'(MULT_CYCLES);
          pend_hi <= prod_s[63:32];
          pend_lo <= prod_s[31:0];
          pend_wr <= 1'b1;
        end
        OP_MULTU: begin
          cnt     <= CW'(MULT_CYCLES);
          pend_hi <= prod_u[63:32];
          pend_lo <= prod_u[31:0];
          pend_wr <= 1'b1;
        end
        OP_DIV: begin
          cnt     <= CW'(DIV_CYCLES);
          pend_hi <= r_s;
          pend_lo <= q_s;
          pend_wr <= (b != 32'd0);
        end
        OP_DIVU: begin
          cnt     <= CW'(DIV_CYCLES);
          pend_hi <= r_u;
          pend_lo <= q_u;
          pend_wr <= (b != 32'd0);
        end
        OP_MTHI: hi <= a;
        OP_MTLO: lo <= a;
        default: ;
      endcase
    end
  end

  assign busy   = (cnt != '0);
  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus hand sequences for
// ignored start-while-busy and reset during a divide.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi_out, lo_out;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op on a negedge, scramble operands after accept, count busy cycles.
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    logic stable;
    logic [31:0] hi0, lo0;
    hi0 = hi_out;
    lo0 = lo_out;
    start = 1'b1; md_op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = v.b + 32'd3; md_op = 3'd5;
    n = 0;
    stable = 1'b1;
    while (busy && n < 50) begin
      if (hi_out !== hi0 || lo_out !== lo0) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.cyc));
    chk($sformatf("v%0d hold_during_busy", idx), {31'd0, stable}, 32'd1);
    chk($sformatf("v%0d hi", idx), hi_out, v.hi);
    chk($sformatf("v%0d lo", idx), lo_out, v.lo);
  endtask

  initial begin
    int n;
    tbl[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    tbl[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[4]  = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    tbl[5]  = '{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'd3,        0};
    tbl[6]  = '{3'd6, 32'h12345678, 32'd0,        32'h12345678, 32'h12345678, 0};
    tbl[7]  = '{3'd3, 32'd5,        32'd0,        32'h12345678, 32'h12345678, 10};
    tbl[8]  = '{3'd4, 32'd9,        32'd0,        32'h12345678, 32'h12345678, 10};
    tbl[9]  = '{3'd0, 32'hAAAA5555, 32'd1,        32'h12345678, 32'h12345678, 0};
    tbl[10] = '{3'd7, 32'hAAAA5555, 32'd1,        32'h12345678, 32'h12345678, 0};
    tbl[11] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[12] = '{3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    tbl[13] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    tbl[14] = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    tbl[15] = '{3'd2, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

    // mult 3*4 with an mtlo pulse during busy cycle 2: must be ignored.
    start = 1'b1; md_op = 3'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 2) begin
        start = 1'b1; md_op = 3'd6; a = 32'h0000DEAD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore busy_cycles", 32'(n), 32'd5);
    chk("ignore lo", lo_out, 32'd12);
    chk("ignore hi", hi_out, 32'd0);
    @(negedge clk);
    chk("ignore busy_after", {31'd0, busy}, 32'd0);
    chk("ignore lo_after", lo_out, 32'd12);

    // divu 100/7 with reset asserted in busy cycle 4.
    start = 1'b1; md_op = 3'd4; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 4) begin
      n++;
      if (n == 4) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    chk("rstmid reached_cycle4", 32'(n), 32'd4);
    chk("rstmid busy", {31'd0, busy}, 32'd0);
    chk("rstmid hi", hi_out, 32'd0);
    chk("rstmid lo", lo_out, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_after%0d busy", k), {31'd0, busy}, 32'd0);
      chk($sformatf("rstmid_after%0d hi", k), hi_out, 32'd0);
      chk($sformatf("rstmid_after%0d lo", k), lo_out, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
